// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame/oversample
// constants common to the baud generator, receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like activity after reset.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver driven by a 16x oversample enable. Bits are sampled at
// their midpoint; completed bytes go to a one-entry valid/ready holding register.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 rxclk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SAMPLE_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST    = BCW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rxclk_en_q;
  logic                 tick;
  rx_state_t            state_q;
  logic [SCW-1:0]       sample_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 stop_sample;
  logic                 byte_done;
  logic                 stop_bad;

  sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i  (system_clk),
    .rst_ni (reset),
    .async_i(rx),
    .sync_o (rx_s)
  );

  // Delay the oversample enable by one clock so its rising edge becomes a one-cycle tick.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      rxclk_en_q <= 1'b0;
    end else begin
      rxclk_en_q <= rxclk_en;
    end
  end

  assign tick        = rxclk_en & ~rxclk_en_q;
  assign stop_sample = tick && (state_q == STOP) && (sample_cnt_q == SAMPLE_LAST);
  assign byte_done   = stop_sample && rx_s;
  assign stop_bad    = stop_sample && !rx_s;

  // Frame state machine: hunts for a start bit, then samples each bit at its centre.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q      <= START;
            sample_cnt_q <= '0;
          end
        end
        START: begin
          if (sample_cnt_q == SAMPLE_MID) begin
            // A line that is high again at the start-bit centre was a glitch.
            state_q      <= rx_s ? IDLE : DATA;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
          end else begin
            sample_cnt_q <= sample_cnt_q + SCW'(1);
          end
        end
        DATA: begin
          if (sample_cnt_q == SAMPLE_LAST) begin
            sample_cnt_q <= '0;
            shift_q      <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q    <= bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= STOP;
            end
          end else begin
            sample_cnt_q <= sample_cnt_q + SCW'(1);
          end
        end
        STOP: begin
          if (sample_cnt_q == SAMPLE_LAST) begin
            // Leaving at the stop-bit centre lets the next start edge be caught.
            state_q      <= rx_s ? IDLE : WAIT_HIGH;
            sample_cnt_q <= '0;
          end else begin
            sample_cnt_q <= sample_cnt_q + SCW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          sample_cnt_q <= '0;
        end
      endcase
    end
  end

  // Holding register handshake plus registered error pulses, evaluated every clock.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: stimulus pushes the expected
// events, a monitor pops and compares whenever the DUT presents one.
module tb_uart_rx_oversample;

  localparam int BIT_CLKS = 128;

  logic       system_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       rxclk_en   = 1'b0;
  logic       rx         = 1'b1;
  logic       rx_ready   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  logic       rose = 1'b0;
  int         ph = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         valid_cycles = 0;
  logic       prev_valid = 1'b0;
  logic [9:0] exp_q[$];

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_OVR  = 2'd2;

  uart_rx_oversample #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial forever #5 system_clk = ~system_clk;

  // Oversample enable: toggles every 4 clocks; rose marks the clock whose posedge is a tick.
  initial forever begin
    @(negedge system_clk);
    ph = ph + 1;
    if (ph == 4) begin
      ph       = 0;
      rxclk_en = ~rxclk_en;
      rose     = rxclk_en;
    end else begin
      rose = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic observe(input logic [9:0] code);
    logic [9:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got 0x%0h, expected none", code);
    end else begin
      e = exp_q.pop_front();
      if (e !== code) begin
        n_fail++;
        $display("FAIL event: got 0x%0h, expected 0x%0h", code, e);
      end
    end
  endtask

  // Monitor: just after each edge, report pulses and newly presented bytes.
  initial forever begin
    @(posedge system_clk);
    #1;
    if (frame_err === 1'b1) observe({K_FERR, 8'h00});
    if (overrun === 1'b1) observe({K_OVR, 8'h00});
    if (rx_valid === 1'b1 && (!prev_valid || rx_ready)) observe({K_BYTE, rx_data});
    if (rx_valid === 1'b1) valid_cycles++;
    prev_valid = (rx_valid === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = stop_bit;
    idle(BIT_CLKS);
  endtask

  // Return at the negedge right after a tick posedge.
  task automatic align_to_tick();
    @(posedge system_clk);
    while (!rose) @(posedge system_clk);
    @(negedge system_clk);
  endtask

  initial begin
    idle(5);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    idle(5);
    reset = 1'b1;
    idle(50);

    // 1: single frame, consumer always ready
    valid_cycles = 0;
    exp_q.push_back({K_BYTE, 8'hA5});
    send_frame(8'hA5, 1'b1);
    idle(64);
    check("t1_drain", exp_q.size(), 0);
    check("t1_valid_cycles", valid_cycles, 1);

    // 2: false start, then a good frame
    rx = 1'b0;
    idle(32);
    rx = 1'b1;
    idle(200);
    check("t2_false_start", exp_q.size(), 0);
    exp_q.push_back({K_BYTE, 8'h3C});
    send_frame(8'h3C, 1'b1);
    idle(64);
    check("t2_drain", exp_q.size(), 0);

    // 3: bad stop bit followed by a long break, then recovery
    exp_q.push_back({K_FERR, 8'h00});
    send_frame(8'h3C, 1'b0);
    idle(3 * 10 * BIT_CLKS);
    rx = 1'b1;
    idle(256);
    check("t3_ferr", exp_q.size(), 0);
    exp_q.push_back({K_BYTE, 8'h81});
    send_frame(8'h81, 1'b1);
    idle(64);
    check("t3_drain", exp_q.size(), 0);

    // 4: back-to-back frames with no consumer -> overrun
    rx_ready = 1'b0;
    exp_q.push_back({K_BYTE, 8'h11});
    exp_q.push_back({K_OVR, 8'h00});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(64);
    check("t4_drain", exp_q.size(), 0);
    check("t4_data", rx_data, 8'h11);
    check("t4_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(1);
    check("t4_cleared", rx_valid, 1'b0);

    // 5: accept the held byte in the same cycle the next one completes
    exp_q.push_back({K_BYTE, 8'h11});
    send_frame(8'h11, 1'b1);
    idle(64);
    check("t5_hold_valid", rx_valid, 1'b1);
    check("t5_hold_data", rx_data, 8'h11);
    exp_q.push_back({K_BYTE, 8'h22});
    align_to_tick();
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(1223);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(64);
    check("t5_drain", exp_q.size(), 0);
    check("t5_data", rx_data, 8'h22);
    check("t5_valid", rx_valid, 1'b1);

    // 6: reset during data bit 4, then a clean frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(5 * BIT_CLKS + 64);
        reset = 1'b0;
        idle(2);
        check("t6_rst_valid", rx_valid, 1'b0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_ferr", frame_err, 1'b0);
        check("t6_rst_ovr", overrun, 1'b0);
        idle(1);
        reset = 1'b1;
      end
    join
    rx_ready = 1'b1;
    idle(200);
    check("t6_no_partial", exp_q.size(), 0);
    exp_q.push_back({K_BYTE, 8'h5A});
    send_frame(8'h5A, 1'b1);
    idle(64);
    check("t6_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver that consumes the 16x oversampling enable from the baud rate generator and deserialises 8N1 frames from the asynchronous rx pin. Line sampling is mid-bit. Received bytes are delivered through a one-entry valid/ready holding register. Framing errors and overruns are reported as single-cycle pulses. The block sits between the pad-level rx input and the byte-stream consumer (command parser or FIFO).

Parameters:
DATA_BITS, 8, data bits per frame; LSB first.
OVERSAMPLE, 16, rxclk_en rising edges per bit period; even, >= 4.
SYNC_STAGES, 2, flops in the rx metastability synchroniser; >= 2.

Ports:
system_clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rxclk_en  input  1  oversample enable from the baud generator. It is a square wave; each rising edge is one oversample tick.
rx  input  1  asynchronous serial line; idle high
rx_data  output  DATA_BITS  received byte; valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
frame_err  output  1  one-cycle pulse; stop bit sampled low
overrun  output  1  one-cycle pulse; completed byte dropped because the holding register was full

Behaviour:
- Clock and reset: all flops clock on system_clk. Reset is synchronous and active-low; it is sampled only on the system_clk edge.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - State is IDLE; counters are 0.
  - Synchroniser flops are 1; rxclk_en_d is 0.
  - Reset mid-frame aborts the frame and discards the partial byte.
- Tick: tick = rxclk_en & ~rxclk_en_d, where rxclk_en_d is rxclk_en registered once. All state and counters advance only on tick, except the output handshake.
- rx_s: the SYNC_STAGES-deep synchronised rx. All decisions use rx_s only.
- Counters:
  - sample_cnt: width $clog2(OVERSAMPLE); reset to 0 on every state change.
  - bit_cnt: width $clog2(DATA_BITS+1).
  - shift: DATA_BITS wide. The new bit enters at the MSB and shift moves right, so the LSB arrives first.
- FSM (transitions happen on tick):
  - IDLE: rx_s=0 -> START.
  - START: increment sample_cnt. At sample_cnt==OVERSAMPLE/2-1, evaluate rx_s:
    - rx_s=0: go to DATA with bit_cnt=0.
    - rx_s=1: false start; return to IDLE with no output.
  - DATA: increment sample_cnt. At sample_cnt==OVERSAMPLE-1, shift in rx_s, clear sample_cnt and increment bit_cnt. When bit_cnt reaches DATA_BITS, go to STOP.
  - STOP: at sample_cnt==OVERSAMPLE-1, evaluate rx_s:
    - rx_s=1: byte complete; go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: rx_s=1 -> IDLE. A held break therefore yields exactly one frame_err.
- Frame end: returning to IDLE mid stop bit allows back-to-back frames.
- Output handshake, evaluated every cycle:
  - Byte complete with (rx_valid=0 or rx_ready=1): load rx_data=shift and set rx_valid=1 on the next edge.
  - Byte complete with rx_valid=1 and rx_ready=0: pulse overrun. rx_data keeps the old byte; rx_valid stays 1.
  - No completion with rx_valid & rx_ready: clear rx_valid.
  - rx_data is stable while rx_valid=1 and not accepted.
- Latency: rx_valid rises one system_clk after the tick that samples the stop-bit midpoint. frame_err and overrun are registered with the same one-clock latency.
- rxclk_en static: no progress and no outputs change; rx_ready still clears rx_valid.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - UART_DATA_BITS=8 and UART_OVERSAMPLE=16 constants, shared with the baud generator and the future transmitter.
- Sub-module sync_bit: SYNC_STAGES-flop synchroniser with a reset value parameter, reused for other async inputs.

Test Plan:
Bench setup: rxclk_en toggles every 4 clocks (tick every 8 clocks, 128 clocks per bit). Frames are driven LSB first. Reset is deasserted at cycle 10.
1. Frame 0xA5 with rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, frame_err=0, overrun=0.
2. rx low for 4 ticks, then high -> FSM back in IDLE; no rx_valid and no frame_err. A following 0x3C frame is received correctly.
3. 0x3C frame with stop bit 0, then rx held low for 3 frame times -> exactly one frame_err pulse and no rx_valid. After rx returns high, frame 0x81 is received as 0x81.
4. Back-to-back 0x11, 0x22 with rx_ready=0 -> rx_data=0x11 and rx_valid=1; one overrun pulse at the end of 0x22; rx_data remains 0x11. Then rx_ready=1 for 1 cycle -> rx_valid=0.
5. rx_valid=1 holding 0x11, with rx_ready=1 in the same cycle that 0x22 completes -> no overrun, rx_data=0x22, rx_valid stays 1.
6. Reset asserted for 3 cycles during data bit 4 of frame 0xFF -> all outputs 0. The next full frame 0x5A yields rx_data=0x5A with no errors.
